// File: rtl/rc4_decrypt.sv
// rc4_decrypt: RC4 keystream generator (PRGA) over S-RAM. XORs each keystream
// byte with the encrypted-message ROM, writes plaintext to the decrypted RAM and
// judges the candidate key (every byte must be a lowercase letter or a space).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a run (sampled only in IDLE)
//   s_q / s_address /
//   s_data / s_wren       S-RAM read data, address, write data, write enable
//   rom_q / rom_address   encrypted-message ROM read data and address (= k)
//   dec_address /
//   dec_data / dec_wren   decrypted-message RAM write port
//   finish                one-cycle pulse when the run completes
//   key_valid             verdict of the last run, held until the next start
module rc4_decrypt #(
  parameter int unsigned MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] s_q,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] rom_q,
  output logic [7:0] rom_address,
  output logic [7:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren,
  output logic       finish,
  output logic       key_valid
);

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] LAST_K = BYTE_W'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE,
    INC_I,
    WAIT_SI,
    READ_SI,
    WAIT_SJ,
    READ_SJ,
    WRITE_I,
    WRITE_J,
    ADDR_F,
    WAIT_F,
    READ_F,
    WRITE_DEC,
    NEXT,
    DONE
  } state_t;

  state_t state;

  logic [BYTE_W-1:0] i, j, k;
  logic [BYTE_W-1:0] si, sj, f, enc;

  // Accepted plaintext alphabet: 'a'..'z' and space.
  function automatic logic is_text(input logic [BYTE_W-1:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  // PRGA sequencer. Memory reads have one cycle of latency after the address
  // register updates, hence the WAIT states. Write address/data are loaded on
  // the edge entering the write state so they are stable while wren is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      sj          <= '0;
      f           <= '0;
      enc         <= '0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      dec_address <= '0;
      dec_data    <= '0;
      dec_wren    <= 1'b0;
      finish      <= 1'b0;
      key_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            key_valid <= 1'b1;
            state     <= INC_I;
          end
        end

        INC_I: begin
          i           <= i + 8'd1;
          s_address   <= i + 8'd1;
          rom_address <= k;
          state       <= WAIT_SI;
        end

        WAIT_SI: state <= READ_SI;

        READ_SI: begin
          si        <= s_q;
          j         <= j + s_q;
          s_address <= j + s_q;
          state     <= WAIT_SJ;
        end

        WAIT_SJ: state <= READ_SJ;

        // Capture S[j] and set up the first swap write S[i] = S[j].
        READ_SJ: begin
          sj        <= s_q;
          enc       <= rom_q;
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state     <= WRITE_I;
        end

        // Second swap write S[j] = old S[i]; when i == j it rewrites the same value.
        WRITE_I: begin
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
          state     <= WRITE_J;
        end

        WRITE_J: begin
          s_wren <= 1'b0;
          state  <= ADDR_F;
        end

        ADDR_F: begin
          s_address <= si + sj;
          state     <= WAIT_F;
        end

        WAIT_F: state <= READ_F;

        READ_F: begin
          f           <= s_q;
          dec_address <= k;
          dec_data    <= s_q ^ enc;
          dec_wren    <= 1'b1;
          state       <= WRITE_DEC;
        end

        // Plaintext byte is written this cycle; a bad byte aborts the run.
        WRITE_DEC: begin
          dec_wren <= 1'b0;
          if (!is_text(f ^ enc)) begin
            key_valid <= 1'b0;
            finish    <= 1'b1;
            state     <= DONE;
          end else begin
            state <= NEXT;
          end
        end

        NEXT: begin
          if (k == LAST_K) begin
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            k     <= k + 8'd1;
            state <= INC_I;
          end
        end

        // Return all memory-side outputs to zero; key_valid is held.
        DONE: begin
          finish      <= 1'b0;
          s_address   <= '0;
          s_data      <= '0;
          s_wren      <= 1'b0;
          rom_address <= '0;
          dec_address <= '0;
          dec_data    <= '0;
          dec_wren    <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt.sv
// Scoreboard bench for rc4_decrypt: a textbook RC4 PRGA model predicts the
// S-RAM swap writes, plaintext writes and finish timing/verdict of each run.
module tb_rc4_decrypt;

  localparam int unsigned MSG_LEN = 32;
  localparam int unsigned LIMIT   = 12 * MSG_LEN + 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] s_q, rom_q;
  logic [7:0] s_address, s_data, rom_address, dec_address, dec_data;
  logic       s_wren, dec_wren, finish, key_valid;

  rc4_decrypt #(.MSG_LEN(MSG_LEN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .s_q        (s_q),
    .s_address  (s_address),
    .s_data     (s_data),
    .s_wren     (s_wren),
    .rom_q      (rom_q),
    .rom_address(rom_address),
    .dec_address(dec_address),
    .dec_data   (dec_data),
    .dec_wren   (dec_wren),
    .finish     (finish),
    .key_valid  (key_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories: data appears one edge after the address.
  logic [7:0] s_mem [256];
  logic [7:0] rom_mem [256];
  logic [7:0] dec_mem [256];
  always @(posedge clk) begin
    s_q   <= s_mem[s_address];
    rom_q <= rom_mem[rom_address];
    if (s_wren)   s_mem[s_address]     <= s_data;
    if (dec_wren) dec_mem[dec_address] <= dec_data;
  end

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { int edge_n; logic kv; } fin_t;
  wr_t  s_exp[$];
  wr_t  d_exp[$];
  fin_t f_exp[$];

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] p [256];        // permutation to load
  logic [7:0] ms [256];       // model S state
  logic [7:0] ks_buf [MSG_LEN];
  logic [7:0] enc_buf [MSG_LEN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic is_text(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // Reference: standard RC4 PRGA over the model S, stopping at the first bad byte.
  task automatic model_run(input int n, output int fin_edge);
    logic [7:0] mi, mj, t, ks, pt;
    logic kv;
    mi = 8'd0; mj = 8'd0; kv = 1'b1;
    fin_edge = n + 12 * MSG_LEN;
    for (int kk = 0; kk < MSG_LEN; kk++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      s_exp.push_back('{mi, ms[mj]});
      s_exp.push_back('{mj, ms[mi]});
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      ks = ms[8'(ms[mi] + ms[mj])];
      pt = ks ^ enc_buf[kk];
      d_exp.push_back('{8'(kk), pt});
      if (!is_text(pt)) begin
        kv = 1'b0;
        fin_edge = n + 12 * kk + 11;
        break;
      end
    end
    f_exp.push_back('{fin_edge, kv});
  endtask

  task automatic gen_ks();
    logic [7:0] c [256];
    logic [7:0] mi, mj, t;
    mi = 8'd0; mj = 8'd0;
    for (int x = 0; x < 256; x++) c[x] = p[x];
    for (int kk = 0; kk < MSG_LEN; kk++) begin
      mi = mi + 8'd1;
      mj = mj + c[mi];
      t = c[mi]; c[mi] = c[mj]; c[mj] = t;
      ks_buf[kk] = c[8'(c[mi] + c[mj])];
    end
  endtask

  task automatic perm_identity();
    for (int x = 0; x < 256; x++) p[x] = 8'(x);
  endtask

  task automatic perm_random();
    logic [7:0] t;
    int y;
    perm_identity();
    for (int x = 255; x > 0; x--) begin
      y = $urandom_range(0, x);
      t = p[x]; p[x] = p[y]; p[y] = t;
    end
  endtask

  task automatic enc_valid();
    int r;
    logic [7:0] pt;
    gen_ks();
    for (int kk = 0; kk < MSG_LEN; kk++) begin
      r  = $urandom_range(0, 26);
      pt = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      enc_buf[kk] = ks_buf[kk] ^ pt;
    end
  endtask

  task automatic enc_random();
    for (int kk = 0; kk < MSG_LEN; kk++) enc_buf[kk] = 8'($urandom);
  endtask

  task automatic load_mem();
    @(negedge clk);
    for (int x = 0; x < 256; x++) begin
      s_mem[x]   <= p[x];
      ms[x]       = p[x];
      dec_mem[x] <= 8'hEE;
      rom_mem[x] <= (x < MSG_LEN) ? enc_buf[x] : 8'h00;
    end
    @(negedge clk);
  endtask

  task automatic wait_finish(input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!finish && c < LIMIT);
    if (!finish) fail_now({name, "_finish_timeout"});
  endtask

  task automatic check_s_final(input string name);
    int errs;
    errs = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) errs++;
    check({name, "_s_final_mismatches"}, errs, 0);
    check({name, "_dec_queue_left"}, d_exp.size(), 0);
  endtask

  task automatic run_one(input string name);
    int n, fe;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    start = 1'b0;
    model_run(n, fe);
    wait_finish(name);
    @(negedge clk);
    @(negedge clk);
    check_s_final(name);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {s_address, s_data, s_wren, rom_address, dec_address, dec_data,
                 dec_wren, finish, key_valid}, 0);
  endtask

  // Monitor: every write or finish pulse the DUT presents is matched against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (s_wren) begin
        if (s_exp.size() == 0) fail_now("s_write_unexpected");
        else begin
          wr_t e;
          e = s_exp.pop_front();
          check("s_write_addr", s_address, e.a);
          check("s_write_data", s_data, e.d);
        end
      end
      if (dec_wren) begin
        if (d_exp.size() == 0) fail_now("dec_write_unexpected");
        else begin
          wr_t e;
          e = d_exp.pop_front();
          check("dec_write_addr", dec_address, e.a);
          check("dec_write_data", dec_data, e.d);
        end
      end
      if (finish) begin
        if (f_exp.size() == 0) fail_now("finish_unexpected");
        else begin
          fin_t e;
          e = f_exp.pop_front();
          check("finish_cycle", cyc, e.edge_n);
          check("finish_key_valid", key_valid, e.kv);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fe1, fe2;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    reset_n = 1'b1;

    // Identity S with a known two-byte prefix; i == j == 1 on the first byte.
    perm_identity();
    enc_valid();
    enc_buf[0] = 8'h63;
    enc_buf[1] = 8'h67;
    load_mem();
    run_one("identity");
    check("identity_dec0", dec_mem[0], 8'h61);
    check("identity_dec1", dec_mem[1], 8'h62);
    check("identity_key_valid", key_valid, 1);

    // Early abort on the very first byte.
    perm_identity();
    enc_random();
    enc_buf[0] = 8'h00;
    load_mem();
    run_one("abort0");
    check("abort0_dec0", dec_mem[0], 8'h02);
    check("abort0_dec1_untouched", dec_mem[1], 8'hEE);
    check("abort0_key_valid", key_valid, 0);

    // S[1] = 0xFF forces j = 0xFF on the first byte.
    perm_random();
    for (int x = 0; x < 256; x++)
      if (p[x] == 8'hFF) begin p[x] = p[1]; p[1] = 8'hFF; end
    enc_valid();
    load_mem();
    run_one("jwrap");

    // Random keys with all-valid plaintext, then random ciphertext.
    for (int r = 0; r < 5; r++) begin
      perm_random();
      enc_valid();
      load_mem();
      run_one("rand_valid");
    end
    for (int r = 0; r < 4; r++) begin
      perm_random();
      enc_random();
      load_mem();
      run_one("rand_enc");
    end

    // Reset during WRITE_J of byte 3, then a clean run.
    perm_random();
    enc_valid();
    load_mem();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    start = 1'b0;
    model_run(n, fe1);
    for (int c = 0; c < 100 && cyc < n + 42; c++) @(negedge clk);
    if (cyc != n + 42) fail_now("reset_reach_write_j");
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset_outputs");
    @(posedge clk);
    s_exp.delete();
    d_exp.delete();
    f_exp.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("after_reset_idle");
    perm_random();
    enc_valid();
    load_mem();
    run_one("post_reset");

    // start held high: mid-run start ignored, second run begins right after DONE.
    perm_random();
    enc_valid();
    load_mem();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    model_run(n, fe1);
    model_run(fe1 + 2, fe2);
    wait_finish("held_run1");
    wait_finish("held_run2");
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_s_final("held");
    check("held_no_extra_finish", f_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
